hpi_access_ctrl: RTL and testbench

HPI_ACCESS_CTRL -- requirements
Module: hpi_access_ctrl

---
 rtl/hpi_pkg.sv | 19 +
 rtl/hpi_int_sync.sv | 31 +++
 rtl/hpi_access_ctrl.sv | 125 ++++++++++++
 tb/tb_hpi_access_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI access controller.
// Holds the FSM state encoding, register selects and counter width.
package hpi_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_t;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_MAILBOX = 2'd1;
   localparam logic [1:0] REG_ADDRESS = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_int_sync.sv
// HPI interrupt resynchronizer into the clk domain.
// HPI_INT_SYNC_EN selects a two-flop chain; otherwise a single register.
module hpi_int_sync (
   input  logic clk,
   input  logic reset,
   input  logic otg_int,
   output logic irq
);

`ifdef HPI_INT_SYNC_EN
   logic meta;

   // two-flop chain for the asynchronous chip interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         irq  <= 1'b0;
      end else begin
         meta <= otg_int;
         irq  <= meta;
      end
   end
`else
   // single retiming register
   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else       irq <= otg_int;
   end
`endif

endmodule

// File: rtl/hpi_access_ctrl.sv
// Avalon-MM slave to Cypress-style HPI bus bridge with timed strobes.
// Optional HPI_INT_SYNC_EN adds a two-flop interrupt synchronizer.
module hpi_access_ctrl
   import hpi_pkg::*;
#(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [15:0] avs_writedata,
   output logic [15:0] avs_readdata,
   output logic        avs_waitrequest,
   output logic [1:0]  otg_addr,
   output logic        otg_cs_n,
   output logic        otg_rd_n,
   output logic        otg_wr_n,
   output logic [15:0] otg_data_out,
   output logic        otg_data_oe,
   input  logic [15:0] otg_data_in,
   input  logic        otg_int,
   output logic        irq
);

   localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic               wr_q, wr_nx;
   logic [1:0]         addr_nx;
   logic [15:0]        dout_nx;
   logic               cs_n_nx, rd_n_nx, wr_n_nx, oe_nx;
   logic               req, latch, cap, last_hold;

   assign req = avs_read | avs_write;

   // next state, phase counter and registered HPI pin values
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt + 4'd1;
      latch     = 1'b0;
      cap       = 1'b0;
      last_hold = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cnt_nx = '0;
            if (req) begin
               state_nx = ST_SETUP;
               latch    = 1'b1;
            end
         end
         ST_SETUP: begin
            if (cnt == SETUP_LAST) begin
               state_nx = ST_STROBE;
               cnt_nx   = '0;
            end
         end
         ST_STROBE: begin
            if (cnt == STROBE_LAST) begin
               state_nx = ST_HOLD;
               cnt_nx   = '0;
               cap      = ~wr_q;
            end
         end
         ST_HOLD: begin
            if (cnt == HOLD_LAST) begin
               state_nx  = ST_IDLE;
               cnt_nx    = '0;
               last_hold = 1'b1;
            end
         end
      endcase
      // a simultaneous read and write resolves to a write
      wr_nx   = latch ? avs_write     : wr_q;
      addr_nx = latch ? avs_address   : otg_addr;
      dout_nx = latch ? avs_writedata : otg_data_out;
      cs_n_nx = (state_nx == ST_IDLE);
      rd_n_nx = ~((state_nx == ST_STROBE) & ~wr_nx);
      wr_n_nx = ~((state_nx == ST_STROBE) & wr_nx);
      oe_nx   = (state_nx != ST_IDLE) & wr_nx;
   end

   assign avs_waitrequest = req & ~last_hold;

   // state register and registered HPI outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         wr_q         <= 1'b0;
         otg_addr     <= 2'd0;
         otg_cs_n     <= 1'b1;
         otg_rd_n     <= 1'b1;
         otg_wr_n     <= 1'b1;
         otg_data_oe  <= 1'b0;
         otg_data_out <= 16'd0;
         avs_readdata <= 16'd0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         wr_q         <= wr_nx;
         otg_addr     <= addr_nx;
         otg_cs_n     <= cs_n_nx;
         otg_rd_n     <= rd_n_nx;
         otg_wr_n     <= wr_n_nx;
         otg_data_oe  <= oe_nx;
         otg_data_out <= dout_nx;
         if (cap) avs_readdata <= otg_data_in;
      end
   end

   hpi_int_sync u_int_sync (
      .clk     (clk),
      .reset   (reset),
      .otg_int (otg_int),
      .irq     (irq)
   );

endmodule

// File: tb/tb_hpi_access_ctrl.sv
// Directed self-checking bench for hpi_access_ctrl (default timing).
// Cycle 0 is the request cycle; later cycles are sampled 2 time units after each rising edge.
module tb_hpi_access_ctrl;
   import hpi_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  avs_address;
   logic        avs_read, avs_write;
   logic [15:0] avs_writedata;
   logic [15:0] avs_readdata;
   logic        avs_waitrequest;
   logic [1:0]  otg_addr;
   logic        otg_cs_n, otg_rd_n, otg_wr_n;
   logic [15:0] otg_data_out;
   logic        otg_data_oe;
   logic [15:0] otg_data_in;
   logic        otg_int;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [15:0] cs_m, rd_m, wr_m, oe_m, wl_m;
   logic        addr_bad, dout_bad;
   logic [15:0] rdata6;

`ifdef HPI_INT_SYNC_EN
   localparam int IRQ_LAT = 2;
`else
   localparam int IRQ_LAT = 1;
`endif

   always #5 clk = ~clk;

   hpi_access_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .avs_address     (avs_address),
      .avs_read        (avs_read),
      .avs_write       (avs_write),
      .avs_writedata   (avs_writedata),
      .avs_readdata    (avs_readdata),
      .avs_waitrequest (avs_waitrequest),
      .otg_addr        (otg_addr),
      .otg_cs_n        (otg_cs_n),
      .otg_rd_n        (otg_rd_n),
      .otg_wr_n        (otg_wr_n),
      .otg_data_out    (otg_data_out),
      .otg_data_oe     (otg_data_oe),
      .otg_data_in     (otg_data_in),
      .otg_int         (otg_int),
      .irq             (irq)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // run one access of ncyc sampled cycles, dropping the request at drop_at
   task automatic run_access(input logic rd, input logic wr,
                             input logic [1:0] a, input logic [15:0] d,
                             input int ncyc, input int drop_at);
      cs_m = '0; rd_m = '0; wr_m = '0; oe_m = '0; wl_m = '0;
      addr_bad = 1'b0; dout_bad = 1'b0; rdata6 = '0;
      step();
      avs_read = rd; avs_write = wr;
      avs_address = a; avs_writedata = d;
      for (int k = 0; k < ncyc; k++) begin
         if (k > 0) begin
            step();
            if (k == drop_at) begin
               avs_read = 1'b0; avs_write = 1'b0;
            end
         end
         #1;
         cs_m[k] = ~otg_cs_n;
         rd_m[k] = ~otg_rd_n;
         wr_m[k] = ~otg_wr_n;
         oe_m[k] = otg_data_oe;
         if (k < drop_at) wl_m[k] = ~avs_waitrequest;
         if (k >= 1 && k <= 6) begin
            if (otg_addr !== a) addr_bad = 1'b1;
            if (wr && otg_data_out !== d) dout_bad = 1'b1;
         end
         if (k == 6) rdata6 = avs_readdata;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      avs_read = 0; avs_write = 0; avs_address = 0;
      avs_writedata = 0; otg_data_in = 0; otg_int = 0;
      step(); step(); step();
      checks++;
      if ({otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe} !== 4'b1110) begin
         errors++;
         $display("FAIL reset_strobes got %b want 1110",
                  {otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe});
      end
      checks++;
      if ({otg_addr, otg_data_out, avs_readdata} !== 34'd0) begin
         errors++;
         $display("FAIL reset_data got %h/%h/%h want 0",
                  otg_addr, otg_data_out, avs_readdata);
      end
      checks++;
      if ({irq, avs_waitrequest} !== 2'b00) begin
         errors++;
         $display("FAIL reset_irq_wait got %b want 00", {irq, avs_waitrequest});
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_read();
      otg_data_in = 16'hBEEF;
      run_access(1'b1, 1'b0, 2'd0, 16'h0000, 10, 7);
      checks++;
      if (cs_m[9:0] !== 10'b00_0111_1110) begin
         errors++;
         $display("FAIL read_cs got %b want 0001111110", cs_m[9:0]);
      end
      checks++;
      if (rd_m[9:0] !== 10'b00_0011_1100) begin
         errors++;
         $display("FAIL read_rd got %b want 0000111100", rd_m[9:0]);
      end
      checks++;
      if ({wr_m[9:0], oe_m[9:0]} !== 20'd0) begin
         errors++;
         $display("FAIL read_wr_oe got %b/%b want 0", wr_m[9:0], oe_m[9:0]);
      end
      checks++;
      if (wl_m[6:0] !== 7'b100_0000) begin
         errors++;
         $display("FAIL read_wait got %b want 1000000", wl_m[6:0]);
      end
      checks++;
      if (rdata6 !== 16'hBEEF || avs_readdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL read_data got %h/%h want beef", rdata6, avs_readdata);
      end
      checks++;
      if (addr_bad !== 1'b0) begin
         errors++;
         $display("FAIL read_addr got bad want 0");
      end
      checks++;
      if (avs_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL idle_wait got %b want 0", avs_waitrequest);
      end
   endtask

   task automatic test_write();
      otg_data_in = 16'h0F0F;
      run_access(1'b0, 1'b1, 2'd2, 16'h1234, 10, 7);
      checks++;
      if (cs_m[9:0] !== 10'b00_0111_1110 || oe_m[9:0] !== 10'b00_0111_1110) begin
         errors++;
         $display("FAIL write_cs_oe got %b/%b want 0001111110",
                  cs_m[9:0], oe_m[9:0]);
      end
      checks++;
      if (wr_m[9:0] !== 10'b00_0011_1100 || rd_m[9:0] !== 10'd0) begin
         errors++;
         $display("FAIL write_strobes got %b/%b want 0000111100/0",
                  wr_m[9:0], rd_m[9:0]);
      end
      checks++;
      if (addr_bad !== 1'b0 || dout_bad !== 1'b0) begin
         errors++;
         $display("FAIL write_addr_data got %b%b want 00", addr_bad, dout_bad);
      end
      checks++;
      if (wl_m[6:0] !== 7'b100_0000) begin
         errors++;
         $display("FAIL write_wait got %b want 1000000", wl_m[6:0]);
      end
      checks++;
      if (avs_readdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL readdata_hold got %h want beef", avs_readdata);
      end
   endtask

   task automatic test_rd_wr_both();
      run_access(1'b1, 1'b1, 2'd1, 16'hABCD, 10, 7);
      checks++;
      if (rd_m[9:0] !== 10'd0 || wr_m[9:0] !== 10'b00_0011_1100) begin
         errors++;
         $display("FAIL both_strobes got rd %b wr %b want 0/0000111100",
                  rd_m[9:0], wr_m[9:0]);
      end
      checks++;
      if (oe_m[9:0] !== 10'b00_0111_1110 || dout_bad !== 1'b0) begin
         errors++;
         $display("FAIL both_oe got %b/%b want 0001111110/0",
                  oe_m[9:0], dout_bad);
      end
   endtask

   task automatic test_reset_mid_read();
      otg_data_in = 16'h5A5A;
      step();
      avs_read = 1'b1; avs_address = 2'd3;
      step(); step(); step();
      reset = 1'b1; avs_read = 1'b0;
      step();
      reset = 1'b0;
      #1;
      checks++;
      if ({otg_cs_n, otg_rd_n} !== 2'b11 || avs_readdata !== 16'd0) begin
         errors++;
         $display("FAIL midreset got cs %b rd %b data %h want 1 1 0000",
                  otg_cs_n, otg_rd_n, avs_readdata);
      end
      checks++;
      if (dut.state !== ST_IDLE) begin
         errors++;
         $display("FAIL midreset_state got %0d want 0", dut.state);
      end
      step(); step();
      checks++;
      if (otg_cs_n !== 1'b1 || avs_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL midreset_idle got cs %b wait %b want 1 0",
                  otg_cs_n, avs_waitrequest);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d8;
      cs_m = '0; wl_m = '0; d8 = '0;
      step();
      avs_write = 1'b1; avs_address = 2'd1; avs_writedata = 16'h1111;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) begin
            step();
            if (k == 7) avs_writedata = 16'h5678;
            if (k == 14) avs_write = 1'b0;
         end
         #1;
         cs_m[k] = ~otg_cs_n;
         if (k < 14) wl_m[k] = ~avs_waitrequest;
         if (k == 8) d8 = otg_data_out;
      end
      checks++;
      if (cs_m !== 16'b0011_1111_0111_1110) begin
         errors++;
         $display("FAIL b2b_cs got %b want 0011111101111110", cs_m);
      end
      checks++;
      if (wl_m[13:0] !== 14'b10_0000_0100_0000) begin
         errors++;
         $display("FAIL b2b_wait got %b want 10000001000000", wl_m[13:0]);
      end
      checks++;
      if (d8 !== 16'h5678) begin
         errors++;
         $display("FAIL b2b_data got %h want 5678", d8);
      end
   endtask

   task automatic test_irq();
      logic [3:0] seen;
      seen = '0;
      otg_int = 1'b0;
      step(); step(); step();
      otg_int = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         #1;
         seen[k] = irq;
      end
      checks++;
      if (seen !== ((4'b1111 << IRQ_LAT) & 4'b1111)) begin
         errors++;
         $display("FAIL irq_rise got %b want lat %0d", seen, IRQ_LAT);
      end
      otg_int = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         #1;
         seen[k] = irq;
      end
      checks++;
      if (seen !== ~((4'b1111 << IRQ_LAT) & 4'b1111)) begin
         errors++;
         $display("FAIL irq_fall got %b want lat %0d", seen, IRQ_LAT);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_rd_wr_both();
      test_reset_mid_read();
      test_back_to_back();
      test_irq();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
